// File: rtl/tt_um_immrudul_updown_counter_if.sv
// Pin bundle for the up/down counter tile: enable, control/data inputs and the three output buses.
// The master side drives the tile inputs and observes its outputs.
interface tt_um_immrudul_updown_counter_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_immrudul_updown_counter.sv
// Prescaled up/down counter with wrap or saturate boundaries, sticky overflow/underflow flags,
// a terminal-count pulse and a compare register, viewable as count or status byte.
module tt_um_immrudul_updown_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count, r_cmp;
    logic [2:0]       r_pre;
    logic             r_tc, r_ovf, r_udf;

    logic [WIDTH-1:0] w_count_nxt, w_cmp_nxt, w_load_val;
    logic [2:0]       w_pre_nxt, w_div_m1;
    logic             w_tc_nxt, w_ovf_nxt, w_udf_nxt;
    logic             w_cnt_en, w_dir, w_load_cnt, w_load_cmp, w_sat, w_view;
    logic             w_tick, w_match;
    logic [7:0]       w_status;

    assign w_cnt_en   = ui_in[0];
    assign w_dir      = ui_in[1];
    assign w_load_cnt = ui_in[2];
    assign w_load_cmp = ui_in[3];
    assign w_sat      = ui_in[4];
    assign w_view     = ui_in[7];
    assign w_load_val = WIDTH'(uio_in);

    always_comb begin
        w_div_m1 = 3'd0;
        unique case (ui_in[6:5])
            2'd0: w_div_m1 = 3'd0;
            2'd1: w_div_m1 = 3'd1;
            2'd2: w_div_m1 = 3'd3;
            2'd3: w_div_m1 = 3'd7;
        endcase
    end

    // >= rather than == so a smaller divisor selected mid-count fires at once
    assign w_tick = ena & w_cnt_en & (r_pre >= w_div_m1);

    always_comb begin
        w_count_nxt = r_count;
        w_cmp_nxt   = r_cmp;
        w_pre_nxt   = r_pre;
        w_tc_nxt    = r_tc;
        w_ovf_nxt   = r_ovf;
        w_udf_nxt   = r_udf;
        if (ena) begin
            w_tc_nxt = 1'b0;
            if (w_load_cmp) begin
                w_cmp_nxt = w_load_val;
            end
            if (w_load_cnt) begin
                w_count_nxt = w_load_val;
                w_pre_nxt   = 3'd0;
                w_ovf_nxt   = 1'b0;
                w_udf_nxt   = 1'b0;
            end else if (w_tick) begin
                w_pre_nxt = 3'd0;
                if (w_dir) begin
                    if (r_count == MAX) begin
                        w_ovf_nxt   = 1'b1;
                        w_tc_nxt    = 1'b1;
                        w_count_nxt = w_sat ? MAX : '0;
                    end else begin
                        w_count_nxt = r_count + WIDTH'(1);
                    end
                end else begin
                    if (r_count == '0) begin
                        w_udf_nxt   = 1'b1;
                        w_tc_nxt    = 1'b1;
                        w_count_nxt = w_sat ? '0 : MAX;
                    end else begin
                        w_count_nxt = r_count - WIDTH'(1);
                    end
                end
            end else if (w_cnt_en) begin
                w_pre_nxt = r_pre + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_cmp   <= MAX;
            r_pre   <= 3'd0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_cmp   <= w_cmp_nxt;
            r_pre   <= w_pre_nxt;
            r_tc    <= w_tc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_udf   <= w_udf_nxt;
        end
    end

    assign w_match  = (r_count == r_cmp);
    assign w_status = {r_tc, w_match, r_ovf, r_udf, w_sat, r_pre};
    assign uo_out   = w_view ? w_status : r_count[7:0];
    assign uio_out  = 8'h00;
    assign uio_oe   = 8'h00;

endmodule

// File: tb/tb_tt_um_immrudul_updown_counter.sv
// Directed bench for the up/down counter tile; inputs change and outputs are sampled on the
// falling clock edge, away from the rising edge where state updates.
module tb_tt_um_immrudul_updown_counter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    tt_um_immrudul_updown_counter_if bus ();

    tt_um_immrudul_updown_counter #(
        .WIDTH (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (bus.ena),
        .ui_in   (bus.ui_in),
        .uio_in  (bus.uio_in),
        .uo_out  (bus.uo_out),
        .uio_out (bus.uio_out),
        .uio_oe  (bus.uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        @(negedge clk);
        checks++;
        if (bus.uo_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_count: got %h want %h", bus.uo_out, 8'h00);
        end
        checks++;
        if (bus.uio_out !== 8'h00 || bus.uio_oe !== 8'h00) begin
            failures++;
            $display("FAIL reset_uio: got %h/%h want 00/00", bus.uio_out, bus.uio_oe);
        end
        bus.ui_in = 8'h80;
        #1;
        checks++;
        if (bus.uo_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_status: got %h want %h", bus.uo_out, 8'h00);
        end
        bus.ui_in = 8'h00;
        rst_n     = 1'b1;
    endtask

    task automatic test_count_up();
        bus.ui_in = 8'h03;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.uo_out !== 8'h05) begin
            failures++;
            $display("FAIL up_count5: got %h want %h", bus.uo_out, 8'h05);
        end
        bus.ui_in = 8'h82;
        #1;
        checks++;
        if (bus.uo_out[6:4] !== 3'b000 || bus.uo_out !== 8'h00) begin
            failures++;
            $display("FAIL up_status: got %h want %h", bus.uo_out, 8'h00);
        end
    endtask

    task automatic test_wrap_saturate();
        bus.ui_in  = 8'h04;
        bus.uio_in = 8'hFE;
        @(negedge clk);
        bus.ui_in = 8'h03;
        @(negedge clk);
        checks++;
        if (bus.uo_out !== 8'hFF) begin
            failures++;
            $display("FAIL wrap_ff: got %h want %h", bus.uo_out, 8'hFF);
        end
        @(negedge clk);
        checks++;
        if (bus.uo_out !== 8'h00) begin
            failures++;
            $display("FAIL wrap_00: got %h want %h", bus.uo_out, 8'h00);
        end
        bus.ui_in = 8'h82;
        #1;
        checks++;
        if (bus.uo_out !== 8'hA0) begin
            failures++;
            $display("FAIL wrap_tc_ovf: got %h want %h", bus.uo_out, 8'hA0);
        end
        @(negedge clk);
        checks++;
        if (bus.uo_out !== 8'h20) begin
            failures++;
            $display("FAIL wrap_tc_clear: got %h want %h", bus.uo_out, 8'h20);
        end
        // saturate pass
        bus.ui_in  = 8'h14;
        bus.uio_in = 8'hFE;
        @(negedge clk);
        bus.ui_in = 8'h13;
        @(negedge clk);
        checks++;
        if (bus.uo_out !== 8'hFF) begin
            failures++;
            $display("FAIL sat_ff: got %h want %h", bus.uo_out, 8'hFF);
        end
        @(negedge clk);
        bus.ui_in = 8'h93;
        #1;
        checks++;
        if (bus.uo_out !== 8'hE8) begin
            failures++;
            $display("FAIL sat_tc1: got %h want %h", bus.uo_out, 8'hE8);
        end
        @(negedge clk);
        checks++;
        if (bus.uo_out !== 8'hE8) begin
            failures++;
            $display("FAIL sat_tc2: got %h want %h", bus.uo_out, 8'hE8);
        end
        bus.ui_in = 8'h13;
        #1;
        checks++;
        if (bus.uo_out !== 8'hFF) begin
            failures++;
            $display("FAIL sat_hold: got %h want %h", bus.uo_out, 8'hFF);
        end
    endtask

    task automatic test_down_underflow();
        bus.ui_in  = 8'h04;
        bus.uio_in = 8'h01;
        @(negedge clk);
        bus.ui_in = 8'h01;
        @(negedge clk);
        checks++;
        if (bus.uo_out !== 8'h00) begin
            failures++;
            $display("FAIL down_00: got %h want %h", bus.uo_out, 8'h00);
        end
        @(negedge clk);
        checks++;
        if (bus.uo_out !== 8'hFF) begin
            failures++;
            $display("FAIL down_ff: got %h want %h", bus.uo_out, 8'hFF);
        end
        bus.ui_in = 8'h80;
        #1;
        checks++;
        if (bus.uo_out !== 8'hD0) begin
            failures++;
            $display("FAIL down_udf: got %h want %h", bus.uo_out, 8'hD0);
        end
        bus.ui_in  = 8'h04;
        bus.uio_in = 8'h10;
        @(negedge clk);
        checks++;
        if (bus.uo_out !== 8'h10) begin
            failures++;
            $display("FAIL down_load: got %h want %h", bus.uo_out, 8'h10);
        end
        bus.ui_in = 8'h80;
        #1;
        checks++;
        if (bus.uo_out !== 8'h00) begin
            failures++;
            $display("FAIL down_udf_clear: got %h want %h", bus.uo_out, 8'h00);
        end
    endtask

    task automatic test_prescale();
        bus.ui_in  = 8'h64;
        bus.uio_in = 8'h00;
        @(negedge clk);
        bus.ui_in = 8'h63;
        repeat (24) @(negedge clk);
        checks++;
        if (bus.uo_out !== 8'h03) begin
            failures++;
            $display("FAIL pre_count3: got %h want %h", bus.uo_out, 8'h03);
        end
        repeat (3) @(negedge clk);
        bus.ena   = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.uo_out !== 8'h03) begin
            failures++;
            $display("FAIL pre_frozen_count: got %h want %h", bus.uo_out, 8'h03);
        end
        bus.ui_in = 8'hE3;
        #1;
        checks++;
        if (bus.uo_out !== 8'h03) begin
            failures++;
            $display("FAIL pre_frozen_status: got %h want %h", bus.uo_out, 8'h03);
        end
        // pre=3 with D=1 selected must tick on the very next edge
        bus.ena   = 1'b1;
        bus.ui_in = 8'h03;
        @(negedge clk);
        checks++;
        if (bus.uo_out !== 8'h04) begin
            failures++;
            $display("FAIL pre_psel_drop: got %h want %h", bus.uo_out, 8'h04);
        end
        @(negedge clk);
        checks++;
        if (bus.uo_out !== 8'h05) begin
            failures++;
            $display("FAIL pre_psel_next: got %h want %h", bus.uo_out, 8'h05);
        end
    endtask

    task automatic test_compare();
        bus.ui_in  = 8'h08;
        bus.uio_in = 8'h07;
        @(negedge clk);
        bus.ui_in  = 8'h04;
        bus.uio_in = 8'h00;
        @(negedge clk);
        bus.ui_in = 8'h83;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            checks++;
            if (bus.uo_out[6] !== (i == 7)) begin
                failures++;
                $display("FAIL cmp_match_%0d: got %b want %b", i, bus.uo_out[6], (i == 7));
            end
        end
        bus.ui_in  = 8'h07;
        bus.uio_in = 8'h55;
        @(negedge clk);
        checks++;
        if (bus.uo_out !== 8'h55) begin
            failures++;
            $display("FAIL cmp_priority: got %h want %h", bus.uo_out, 8'h55);
        end
    endtask

    task automatic test_async_reset();
        bus.ui_in  = 8'h04;
        bus.uio_in = 8'h42;
        @(negedge clk);
        bus.ui_in = 8'h03;
        checks++;
        if (bus.uo_out !== 8'h42) begin
            failures++;
            $display("FAIL ar_load: got %h want %h", bus.uo_out, 8'h42);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.uo_out !== 8'h00) begin
            failures++;
            $display("FAIL ar_immediate: got %h want %h", bus.uo_out, 8'h00);
        end
        bus.ui_in = 8'h80;
        #1;
        checks++;
        if (bus.uo_out !== 8'h00) begin
            failures++;
            $display("FAIL ar_status: got %h want %h", bus.uo_out, 8'h00);
        end
        bus.ui_in = 8'h03;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.uo_out !== 8'h01) begin
            failures++;
            $display("FAIL ar_resume: got %h want %h", bus.uo_out, 8'h01);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_count_up();
        test_wrap_saturate();
        test_down_underflow();
        test_prescale();
        test_compare();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
